dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the core's load/store port; it is the slave end of the core's wr/rd/addr/wr_data interface.
- Accepts one load or store at a time and stalls the pipeline through a ready/valid handshake.
- Stores into a byte-addressable little-endian RAM, returns sized and sign- or zero-extended load data, and flags misaligned or illegal accesses.
- Inserts a parameterised number of wait states so stall paths in the pipeline can be exercised.

Parameters:
- DATA_W, 32, data width in bits; only 32 is supported.
- ADDR_W, 9, byte-address width; RAM holds 2**ADDR_W bytes (default 512 bytes = 128 words).
- WAIT_CYCLES, 1, extra cycles between request acceptance and response; legal range 0..15.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- reset  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_we  input  1  store request (MemWrite).
- req_re  input  1  load request (MemRead).
- req_addr  input  ADDR_W  byte address.
- req_funct3  input  3  access size and sign, RISC-V funct3 encoding.
- req_wdata  input  DATA_W  store data; the sub-word is taken from the low bits.
- req_ready  output  1  responder can accept a request this cycle.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  DATA_W  load result; valid only when rsp_valid is high.
- rsp_err  output  1  access rejected; valid only when rsp_valid is high.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and the wait counter clears.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - RAM contents are not cleared.
- States:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0.
  - RESP: req_ready=0, rsp_valid=1.
- Acceptance:
  - A request is accepted when state=IDLE, req_valid=1, and (req_we|req_re)=1.
  - req_valid with both req_we and req_re low is ignored; the responder stays in IDLE.
  - On acceptance, addr, funct3, wdata, we and re are captured into internal registers.
  - Request inputs are ignored outside IDLE.
- Transitions:
  - IDLE to RESP if WAIT_CYCLES=0.
  - Otherwise IDLE to WAIT, loading cnt=WAIT_CYCLES-1.
  - WAIT to RESP when cnt=0; otherwise cnt decrements.
  - RESP to IDLE unconditionally.
- Latency:
  - For a request accepted in cycle N, rsp_valid is high in cycle N+1+WAIT_CYCLES for exactly one cycle.
  - req_ready is low from N+1 through the response cycle and high again the cycle after.
  - At most one request is outstanding.
- Error check (on the captured request), rsp_err=1 when any of:
  - req_we and req_re are both high.
  - A load's funct3 is not in {000,001,010,100,101}.
  - A store's funct3 is not in {000,001,010}.
  - Half access with addr[0]≠0.
  - Word access with addr[1:0]≠0.
  - On error, RAM is unchanged and rsp_rdata=0.
- Store:
  - The RAM write commits at the clock edge that enters RESP.
  - SB writes byte addr with wdata[7:0].
  - SH writes bytes addr and addr+1 with wdata[15:0], little-endian.
  - SW writes 4 bytes.
  - rsp_rdata=0 and rsp_err=0 in the response.
- Load:
  - RAM is read at the edge entering RESP and registered into rsp_rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word.
  - A load always observes all previously completed stores.
- Outside the response cycle, rsp_rdata=0 and rsp_err=0.
- Address wrap: none is possible, since aligned accesses never cross the top of the RAM.
- Reset mid-operation: the pending request is dropped with no response. A store not yet committed (reset before the edge entering RESP) leaves RAM unchanged.

Test Plan:
- WAIT_CYCLES=1: SW 0xDEADBEEF at 0x010 accepted cycle N -> rsp_valid only at N+2, req_ready low N+1..N+2. Then LW 0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
- Sized loads after the above:
  - LB 0x013 -> 0xFFFFFFDE.
  - LBU 0x013 -> 0x000000DE.
  - LH 0x012 -> 0xFFFFDEAD.
  - LHU 0x012 -> 0x0000DEAD.
  - LB 0x010 -> 0xFFFFFFEF.
- SB wdata=0x1234565A at 0x011, then LW 0x010 -> 0xDEAD5AEF. SH 0xABCD at 0x012, then LW 0x010 -> 0xABCD5AEF.
- Error cases:
  - LW 0x012 -> rsp_err=1, rsp_rdata=0.
  - SH at 0x011 -> rsp_err=1, then LW 0x010 still 0xABCD5AEF.
  - req_we=req_re=1 -> rsp_err=1.
  - funct3=011 load -> rsp_err=1.
- Backpressure, WAIT_CYCLES=3: req_valid held high continuously with a second LW -> second acceptance exactly 5 cycles after the first. req_valid=1 with we=re=0 in IDLE -> no response, req_ready stays 1.
- SW 0x11111111 to 0x020 (old value 0x0) with reset pulsed low during WAIT -> no rsp_valid, all outputs at reset values. After release, LW 0x020 -> 0x00000000.

Source files
------------

// File: rtl/dmem_responder_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : dmem_responder_if
// Description : Load/store request and response bundle between the core's
//               data port (master) and the data-memory responder (slave).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface dmem_responder_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic              req_re;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_funct3;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid,
        output req_we,
        output req_re,
        output req_addr,
        output req_funct3,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_re,
        input  req_addr,
        input  req_funct3,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err
    );
endinterface : dmem_responder_if
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : dmem_responder
// Description : Byte-addressable little-endian data RAM answering one load or
//               store at a time, with configurable wait states and error flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module dmem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);

    localparam int         c_depth    = 2 ** ADDR_W;
    localparam logic [3:0] c_cnt_init = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_cnt;

    logic               r_we;
    logic               r_re;
    logic [ADDR_W-1:0]  r_addr;
    logic [2:0]         r_funct3;
    logic [DATA_W-1:0]  r_wdata;

    logic [DATA_W-1:0]  r_rdata;
    logic               r_err;

    logic               w_ready;
    logic               w_accept;
    logic               w_enter_resp;

    logic               w_cur_we;
    logic               w_cur_re;
    logic [ADDR_W-1:0]  w_cur_addr;
    logic [2:0]         w_cur_funct3;
    logic [DATA_W-1:0]  w_cur_wdata;

    logic               w_size_ok;
    logic               w_align_ok;
    logic               w_err;

    logic [ADDR_W-1:0]  w_a0;
    logic [ADDR_W-1:0]  w_a1;
    logic [ADDR_W-1:0]  w_a2;
    logic [ADDR_W-1:0]  w_a3;
    logic [7:0]         w_b0;
    logic [7:0]         w_b1;
    logic [7:0]         w_b2;
    logic [7:0]         w_b3;
    logic [DATA_W-1:0]  w_load_data;

    logic [7:0]         r_mem [0:c_depth-1];

    assign w_accept = (r_state == S_IDLE) && bus.req_valid && (bus.req_we || bus.req_re);

    // With zero wait states the access completes on the accepting edge, before
    // the capture registers are loaded, so the live request is used in IDLE.
    assign w_cur_we     = (r_state == S_IDLE) ? bus.req_we     : r_we;
    assign w_cur_re     = (r_state == S_IDLE) ? bus.req_re     : r_re;
    assign w_cur_addr   = (r_state == S_IDLE) ? bus.req_addr   : r_addr;
    assign w_cur_funct3 = (r_state == S_IDLE) ? bus.req_funct3 : r_funct3;
    assign w_cur_wdata  = (r_state == S_IDLE) ? bus.req_wdata  : r_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_ready      = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_next       = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next       = S_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= c_cnt_init;
        end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we     <= 1'b0;
            r_re     <= 1'b0;
            r_addr   <= '0;
            r_funct3 <= 3'b000;
            r_wdata  <= '0;
        end else if (w_accept) begin
            r_we     <= bus.req_we;
            r_re     <= bus.req_re;
            r_addr   <= bus.req_addr;
            r_funct3 <= bus.req_funct3;
            r_wdata  <= bus.req_wdata;
        end
    end

    // Unsigned sizes are load-only; stores reach them with w_cur_re low.
    always_comb begin
        w_size_ok  = 1'b0;
        w_align_ok = 1'b1;
        case (w_cur_funct3)
            c_f3_b: begin
                w_size_ok = 1'b1;
            end
            c_f3_h: begin
                w_size_ok  = 1'b1;
                w_align_ok = ~w_cur_addr[0];
            end
            c_f3_w: begin
                w_size_ok  = 1'b1;
                w_align_ok = (w_cur_addr[1:0] == 2'b00);
            end
            c_f3_bu: begin
                w_size_ok = w_cur_re;
            end
            c_f3_hu: begin
                w_size_ok  = w_cur_re;
                w_align_ok = ~w_cur_addr[0];
            end
            default: begin
                w_size_ok = 1'b0;
            end
        endcase
        w_err = (w_cur_we & w_cur_re) | ~w_size_ok | ~w_align_ok;
    end

    assign w_a0 = w_cur_addr;
    assign w_a1 = w_cur_addr + ADDR_W'(1);
    assign w_a2 = w_cur_addr + ADDR_W'(2);
    assign w_a3 = w_cur_addr + ADDR_W'(3);

    assign w_b0 = r_mem[w_a0];
    assign w_b1 = r_mem[w_a1];
    assign w_b2 = r_mem[w_a2];
    assign w_b3 = r_mem[w_a3];

    always_comb begin
        w_load_data = '0;
        case (w_cur_funct3)
            c_f3_b:  w_load_data = {{24{w_b0[7]}}, w_b0};
            c_f3_bu: w_load_data = {24'd0, w_b0};
            c_f3_h:  w_load_data = {{16{w_b1[7]}}, w_b1, w_b0};
            c_f3_hu: w_load_data = {16'd0, w_b1, w_b0};
            c_f3_w:  w_load_data = {w_b3, w_b2, w_b1, w_b0};
            default: w_load_data = '0;
        endcase
    end

    // RAM has no reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_enter_resp && w_cur_we && !w_err) begin
            case (w_cur_funct3[1:0])
                2'b00: begin
                    r_mem[w_a0] <= w_cur_wdata[7:0];
                end
                2'b01: begin
                    r_mem[w_a0] <= w_cur_wdata[7:0];
                    r_mem[w_a1] <= w_cur_wdata[15:8];
                end
                2'b10: begin
                    r_mem[w_a0] <= w_cur_wdata[7:0];
                    r_mem[w_a1] <= w_cur_wdata[15:8];
                    r_mem[w_a2] <= w_cur_wdata[23:16];
                    r_mem[w_a3] <= w_cur_wdata[31:24];
                end
                default: begin
                end
            endcase
        end
    end

    // Response registers hold data only during the RESP cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_enter_resp) begin
            r_rdata <= (w_cur_re && !w_err) ? w_load_data : '0;
            r_err   <= w_err;
        end else begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_dmem_responder
// Description : Scoreboard bench for dmem_responder at WAIT_CYCLES 1 and 3.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_dmem_responder;

    logic clk;
    logic reset;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    logic [32:0] q1[$];
    logic [32:0] q3[$];

    dmem_responder_if #(.ADDR_W(9), .DATA_W(32)) b1 ();
    dmem_responder_if #(.ADDR_W(9), .DATA_W(32)) b3 ();

    dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.slave)
    );

    dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b3.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitors: pop the expected {rdata, err} whenever a response strobes.
    always @(negedge clk) begin
        if (b1.rsp_valid === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d1_unexpected_rsp actual=%h/%b required=no_response", b1.rsp_rdata, b1.rsp_err);
            end else begin
                check("d1_rsp", {b1.rsp_rdata, b1.rsp_err}, q1.pop_front());
            end
        end else begin
            check("d1_idle_out", {b1.rsp_rdata, b1.rsp_err}, 33'd0);
        end
    end

    always @(negedge clk) begin
        if (b3.rsp_valid === 1'b1) begin
            if (q3.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d3_unexpected_rsp actual=%h/%b required=no_response", b3.rsp_rdata, b3.rsp_err);
            end else begin
                check("d3_rsp", {b3.rsp_rdata, b3.rsp_err}, q3.pop_front());
            end
        end else begin
            check("d3_idle_out", {b3.rsp_rdata, b3.rsp_err}, 33'd0);
        end
    end

    task automatic req1(input string name, input logic we, input logic re, input logic [8:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd, input logic [31:0] er, input logic ee);
        int   n_acc;
        int   t;
        logic rdy_bad;
        @(negedge clk);
        b1.req_valid = 1'b1; b1.req_we = we; b1.req_re = re;
        b1.req_addr = addr; b1.req_funct3 = f3; b1.req_wdata = wd;
        t = 0;
        while (b1.req_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        q1.push_back({er, ee});
        n_acc = cyc;
        @(negedge clk);
        b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_re = 1'b0;
        rdy_bad = 1'b0;
        t = 0;
        while (b1.rsp_valid !== 1'b1 && t < 20) begin
            if (b1.req_ready !== 1'b0) rdy_bad = 1'b1;
            @(negedge clk);
            t++;
        end
        if (b1.req_ready !== 1'b0) rdy_bad = 1'b1;
        check({name, "_latency"}, 33'(cyc - n_acc), 33'd2);
        check({name, "_ready_low"}, {32'd0, rdy_bad}, 33'd0);
        @(negedge clk);
        check({name, "_ready_back"}, {32'd0, b1.req_ready}, 33'd1);
    endtask

    task automatic req3(input logic we, input logic re, input logic [8:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd, input logic [31:0] er, input logic ee);
        int t;
        @(negedge clk);
        b3.req_valid = 1'b1; b3.req_we = we; b3.req_re = re;
        b3.req_addr = addr; b3.req_funct3 = f3; b3.req_wdata = wd;
        t = 0;
        while (b3.req_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        q3.push_back({er, ee});
        @(negedge clk);
        b3.req_valid = 1'b0; b3.req_we = 1'b0; b3.req_re = 1'b0;
        t = 0;
        while (b3.rsp_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   t;
        int   a1;
        int   a2;
        logic bad;

        reset = 1'b1;
        b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_re = 1'b0;
        b1.req_addr = '0; b1.req_funct3 = 3'b000; b1.req_wdata = '0;
        b3.req_valid = 1'b0; b3.req_we = 1'b0; b3.req_re = 1'b0;
        b3.req_addr = '0; b3.req_funct3 = 3'b000; b3.req_wdata = '0;
        #1 reset = 1'b0;
        #1;
        check("d1_reset_out", {30'd0, b1.req_ready, b1.rsp_valid, b1.rsp_err}, 33'b100);
        check("d1_reset_rdata", {1'b0, b1.rsp_rdata}, 33'd0);
        check("d3_reset_out", {30'd0, b3.req_ready, b3.rsp_valid, b3.rsp_err}, 33'b100);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // WAIT_CYCLES=1: stores, sized loads, errors
        req1("sw_010",   1, 0, 9'h010, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0);
        req1("lw_010",   0, 1, 9'h010, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);
        req1("lb_013",   0, 1, 9'h013, 3'b000, 32'h0, 32'hFFFFFFDE, 1'b0);
        req1("lbu_013",  0, 1, 9'h013, 3'b100, 32'h0, 32'h000000DE, 1'b0);
        req1("lh_012",   0, 1, 9'h012, 3'b001, 32'h0, 32'hFFFFDEAD, 1'b0);
        req1("lhu_012",  0, 1, 9'h012, 3'b101, 32'h0, 32'h0000DEAD, 1'b0);
        req1("lb_010",   0, 1, 9'h010, 3'b000, 32'h0, 32'hFFFFFFEF, 1'b0);
        req1("sb_011",   1, 0, 9'h011, 3'b000, 32'h1234565A, 32'h0, 1'b0);
        req1("lw_sb",    0, 1, 9'h010, 3'b010, 32'h0, 32'hDEAD5AEF, 1'b0);
        req1("sh_012",   1, 0, 9'h012, 3'b001, 32'h0000ABCD, 32'h0, 1'b0);
        req1("lw_sh",    0, 1, 9'h010, 3'b010, 32'h0, 32'hABCD5AEF, 1'b0);
        req1("lw_mis",   0, 1, 9'h012, 3'b010, 32'h0, 32'h0, 1'b1);
        req1("sh_mis",   1, 0, 9'h011, 3'b001, 32'hFFFFFFFF, 32'h0, 1'b1);
        req1("we_re",    1, 1, 9'h010, 3'b010, 32'h55555555, 32'h0, 1'b1);
        req1("ld_f3_011", 0, 1, 9'h010, 3'b011, 32'h0, 32'h0, 1'b1);
        req1("st_f3_100", 1, 0, 9'h010, 3'b100, 32'h77777777, 32'h0, 1'b1);
        req1("lw_after_err", 0, 1, 9'h010, 3'b010, 32'h0, 32'hABCD5AEF, 1'b0);
        req1("sw_1fc",   1, 0, 9'h1FC, 3'b010, 32'h0BADF00D, 32'h0, 1'b0);
        req1("lbu_1ff",  0, 1, 9'h1FF, 3'b100, 32'h0, 32'h0000000B, 1'b0);
        req1("lh_1fe",   0, 1, 9'h1FE, 3'b001, 32'h0, 32'h00000BAD, 1'b0);
        req1("lb_1fd",   0, 1, 9'h1FD, 3'b000, 32'h0, 32'hFFFFFFF0, 1'b0);

        // WAIT_CYCLES=3: back-to-back acceptance with req_valid held high
        req3(1, 0, 9'h000, 3'b010, 32'hCAFEF00D, 32'h0, 1'b0);
        @(negedge clk);
        b3.req_valid = 1'b1; b3.req_we = 1'b0; b3.req_re = 1'b1;
        b3.req_addr = 9'h000; b3.req_funct3 = 3'b010;
        t = 0;
        while (b3.req_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        a1 = cyc;
        q3.push_back({32'hCAFEF00D, 1'b0});
        @(negedge clk);
        t = 0;
        while (b3.req_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        a2 = cyc;
        q3.push_back({32'hCAFEF00D, 1'b0});
        check("bp_accept_gap", 33'(a2 - a1), 33'd5);
        @(negedge clk);
        b3.req_valid = 1'b0; b3.req_re = 1'b0;
        repeat (8) @(negedge clk);

        // req_valid with neither we nor re: no response, stays ready
        b3.req_valid = 1'b1; b3.req_we = 1'b0; b3.req_re = 1'b0;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (b3.req_ready !== 1'b1) bad = 1'b1;
        end
        b3.req_valid = 1'b0;
        check("noop_ready_held", {32'd0, bad}, 33'd0);

        // Reset during WAIT drops an uncommitted store
        req3(1, 0, 9'h020, 3'b010, 32'h00000000, 32'h0, 1'b0);
        @(negedge clk);
        b3.req_valid = 1'b1; b3.req_we = 1'b1; b3.req_re = 1'b0;
        b3.req_addr = 9'h020; b3.req_funct3 = 3'b010; b3.req_wdata = 32'h11111111;
        @(negedge clk);
        b3.req_valid = 1'b0; b3.req_we = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_reset_out", {30'd0, b3.req_ready, b3.rsp_valid, b3.rsp_err}, 33'b100);
        check("mid_reset_rdata", {1'b0, b3.rsp_rdata}, 33'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        req3(0, 1, 9'h020, 3'b010, 32'h0, 32'h00000000, 1'b0);

        repeat (4) @(negedge clk);
        check("q1_drained", 33'(q1.size()), 33'd0);
        check("q3_drained", 33'(q3.size()), 33'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire
